// File: rtl/niosii_sys_tick_pkg.sv
// Shared types and constants for the system tick scheduler: FSM states,
// interval timer s1 register map and default sizing.
package niosii_sys_tick_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EN,
    ST_WAIT,
    ST_RD,
    ST_CHK,
    ST_CLR,
    ST_UPD,
    ST_DIS
  } state_t;

  localparam logic [2:0]  ADDR_STATUS  = 3'd0;
  localparam logic [2:0]  ADDR_CONTROL = 3'd1;
  localparam logic [15:0] CTRL_ITO     = 16'h0001;
  localparam logic [15:0] CTRL_OFF     = 16'h0000;
  localparam logic [15:0] STATUS_CLR   = 16'h0000;

  localparam int DEFAULT_NUM_CH = 4;
  localparam int DEFAULT_TICK_W = 16;

endpackage

// File: rtl/niosii_sys_tick_channel.sv
// One periodic tick channel: counts whole serviced ticks down from its period
// and flags expiry with a pulse, a sticky pending bit and a sticky overrun bit.
module niosii_sys_tick_channel
  import niosii_sys_tick_pkg::*;
#(
  parameter int TICK_W = DEFAULT_TICK_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              upd,
  input  logic              period_wr,
  input  logic [TICK_W-1:0] period_in,
  input  logic              cnt_en,
  input  logic              ack,
  output logic              expiry_pulse,
  output logic              pending,
  output logic              missed
);

  logic [TICK_W-1:0] period;
  logic [TICK_W-1:0] cnt;
  logic              active;
  logic              expire;

  // A period load always wins over a same-cycle tick update.
  assign active = upd && cnt_en && (period != '0) && !period_wr;
  assign expire = active && (cnt == TICK_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period       <= '0;
      cnt          <= '0;
      expiry_pulse <= 1'b0;
      pending      <= 1'b0;
      missed       <= 1'b0;
    end else begin
      expiry_pulse <= expire;
      if (period_wr) begin
        period <= period_in;
        cnt    <= period_in;
      end else if (active) begin
        cnt <= expire ? period : cnt - TICK_W'(1);
      end
      // An ack landing on an expiry is overridden and does not count as a miss.
      if (expire) begin
        pending <= 1'b1;
        if (pending && !ack) missed <= 1'b1;
      end else if (ack) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/niosii_sys_tick_scheduler.sv
// Avalon-MM master for the interval timer s1 port: arms its interrupt, services
// each timeout and fans the resulting tick out to NUM_CH periodic channels.
module niosii_sys_tick_scheduler
  import niosii_sys_tick_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int TICK_W = DEFAULT_TICK_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq,
  input  logic              ch_period_wr,
  input  logic [2:0]        ch_sel,
  input  logic [TICK_W-1:0] ch_period,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] ch_ack,
  output logic [NUM_CH-1:0] ch_event,
  output logic [NUM_CH-1:0] ch_pending,
  output logic [NUM_CH-1:0] ch_missed,
  output logic [31:0]       tick_count
);

  state_t      state;
  state_t      next_state;
  logic        bus_cs;
  logic        bus_wn;
  logic [2:0]  bus_addr;
  logic [15:0] bus_data;
  logic        upd;
  logic        unused_rdata;

  assign unused_rdata = ^tmr_readdata[15:1];
  assign upd          = (state == ST_UPD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // enable is only looked at in IDLE/WAIT so a started service always finishes.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (enable) next_state = ST_EN;
      ST_EN:   next_state = ST_WAIT;
      ST_WAIT: begin
        if (!enable)      next_state = ST_DIS;
        else if (tmr_irq) next_state = ST_RD;
      end
      ST_RD:   next_state = ST_CHK;
      ST_CHK:  next_state = tmr_readdata[0] ? ST_CLR : ST_WAIT;
      ST_CLR:  next_state = ST_UPD;
      ST_UPD:  next_state = ST_WAIT;
      ST_DIS:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Bus values are decoded from next_state so the registered outputs line up
  // with the state they belong to; CHK keeps address 0 for the read sample.
  always_comb begin
    bus_cs   = 1'b0;
    bus_wn   = 1'b1;
    bus_addr = ADDR_STATUS;
    bus_data = '0;
    case (next_state)
      ST_EN: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = ADDR_CONTROL;
        bus_data = CTRL_ITO;
      end
      ST_RD:  bus_cs = 1'b1;
      ST_CLR: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_data = STATUS_CLR;
      end
      ST_DIS: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = ADDR_CONTROL;
        bus_data = CTRL_OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= '0;
      tmr_writedata  <= '0;
      tick_count     <= '0;
    end else begin
      tmr_chipselect <= bus_cs;
      tmr_write_n    <= bus_wn;
      tmr_address    <= bus_addr;
      tmr_writedata  <= bus_data;
      if (upd) tick_count <= tick_count + 32'd1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    niosii_sys_tick_channel #(
      .TICK_W(TICK_W)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .upd          (upd),
      .period_wr    (ch_period_wr && (ch_sel == 3'(i))),
      .period_in    (ch_period),
      .cnt_en       (ch_enable[i]),
      .ack          (ch_ack[i]),
      .expiry_pulse (ch_event[i]),
      .pending      (ch_pending[i]),
      .missed       (ch_missed[i])
    );
  end

endmodule
